segasys1_sndlatch: RTL and testbench



---
 rtl/segasys1_snd_pkg.sv | 17 +
 rtl/segasys1_sndfifo.sv | 81 ++++++++
 rtl/segasys1_sndlatch.sv | 155 +++++++++++++++
 tb/tb_segasys1_sndlatch.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/segasys1_snd_pkg.sv
// Shared types and default constants for the System 1 sound-command receiver.
// The FIFO storage option is selected by the SNDLATCH_FIFO_EN macro in the top module.
package segasys1_snd_pkg;

    localparam int CMD_W          = 8;
    localparam int IRQ_PERIOD_DEF = 200000;
    localparam int IRQ_WIDTH_DEF  = 256;
    localparam int NMI_GAP_DEF    = 64;
    localparam int FIFO_AW_DEF    = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GAP    = 2'd2
    } nmi_state_t;

endpackage

// File: rtl/segasys1_sndfifo.sv
// Synchronous command FIFO with a registered head; a write while full is accepted
// only when a read frees a slot in the same cycle.
module segasys1_sndfifo
    import segasys1_snd_pkg::*;
#(
    parameter int AW = FIFO_AW_DEF,
    parameter int W  = CMD_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_wr_en,
    input  logic         i_rd_en,
    input  logic [W-1:0] i_wr_data,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_head
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [W-1:0]  r_head;

    logic          w_rd;
    logic          w_wr;
    logic [AW-1:0] w_rd_ptr_inc;

    assign o_full       = (r_count == CNT_FULL);
    assign o_empty      = (r_count == '0);
    assign o_head       = r_head;
    assign w_rd         = i_rd_en & ~o_empty;
    assign w_wr         = i_wr_en & (~o_full | w_rd);
    assign w_rd_ptr_inc = r_rd_ptr + PTR_ONE;

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            if (w_wr && !w_rd) begin
                r_count <= r_count + CNT_ONE;
            end else if (w_rd && !w_wr) begin
                r_count <= r_count - CNT_ONE;
            end
            // Head only moves on a write into an empty FIFO or on a read; an emptying
            // read leaves the last popped byte visible.
            if (w_wr && o_empty) begin
                r_head <= i_wr_data;
            end else if (w_rd) begin
                if (r_count == CNT_ONE) begin
                    if (w_wr) begin
                        r_head <= i_wr_data;
                    end
                end else begin
                    r_head <= r_mem[w_rd_ptr_inc];
                end
            end
        end
    end

endmodule

// File: rtl/segasys1_sndlatch.sv
// Sound-command receiver: main-CPU write capture, NMI pacing and periodic IRQ.
// Define SNDLATCH_FIFO_EN for a 2^FIFO_AW command FIFO instead of the single latch.
module segasys1_sndlatch
    import segasys1_snd_pkg::*;
#(
    parameter int IRQ_PERIOD = IRQ_PERIOD_DEF,
    parameter int IRQ_WIDTH  = IRQ_WIDTH_DEF,
    parameter int NMI_GAP    = NMI_GAP_DEF,
    parameter int FIFO_AW    = FIFO_AW_DEF
) (
    input  logic             CLK48M,
    input  logic             RESET,
    input  logic             SNDRQ,
    input  logic [CMD_W-1:0] CPUDO,
    input  logic             SCPU_CS_LATCH,
    output logic [CMD_W-1:0] SCPU_LATCH_DO,
    output logic             SCPU_NMI,
    output logic             SCPU_IRQ,
    output logic             PENDING,
    output logic             OVERRUN
);

    localparam int IW = $clog2(IRQ_PERIOD);
    localparam int GW = $clog2(NMI_GAP + 1);
    localparam logic [IW-1:0] IRQ_LAST = IW'(IRQ_PERIOD - 1);
    localparam logic [IW-1:0] IRQ_ON   = IW'(IRQ_PERIOD - IRQ_WIDTH);
    localparam logic [IW-1:0] IRQ_ONE  = 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(NMI_GAP - 1);
    localparam logic [GW-1:0] GAP_ONE  = 1;

    if (IRQ_WIDTH < 1 || IRQ_WIDTH >= IRQ_PERIOD || NMI_GAP < 1 || FIFO_AW < 1) begin : g_bad_params
        $error("segasys1_sndlatch: parameter out of range");
    end

    logic             r_sndrq_d;
    logic             r_cs_d;
    logic             r_overrun;
    logic [IW-1:0]    r_irq_cnt;
    nmi_state_t       r_state;
    nmi_state_t       w_state_next;
    logic [GW-1:0]    r_gap_cnt;
    logic [GW-1:0]    w_gap_cnt_next;

    logic             w_wr;
    logic             w_pop;
    logic             w_pending;
    logic             w_ovr_set;
    logic [CMD_W-1:0] w_do;

    assign w_wr  = SNDRQ & ~r_sndrq_d;
    // The pop fires when the sound CPU ends its read, and only if something is queued.
    assign w_pop = ~SCPU_CS_LATCH & r_cs_d & w_pending;

`ifdef SNDLATCH_FIFO_EN
    logic w_full;
    logic w_empty;

    segasys1_sndfifo #(
        .AW (FIFO_AW),
        .W  (CMD_W)
    ) u_fifo (
        .i_clk     (CLK48M),
        .i_rst     (RESET),
        .i_wr_en   (w_wr),
        .i_rd_en   (w_pop),
        .i_wr_data (CPUDO),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_head    (w_do)
    );

    assign w_pending = ~w_empty;
    assign w_ovr_set = w_wr & w_full & ~w_pop;
`else
    logic             r_pending;
    logic [CMD_W-1:0] r_latch;

    always_ff @(posedge CLK48M) begin
        if (RESET) begin
            r_pending <= 1'b0;
            r_latch   <= '0;
        end else if (w_wr) begin
            r_pending <= 1'b1;
            r_latch   <= CPUDO;
        end else if (w_pop) begin
            r_pending <= 1'b0;
        end
    end

    assign w_pending = r_pending;
    assign w_do      = r_latch;
    assign w_ovr_set = w_wr & r_pending & ~w_pop;
`endif

    always_ff @(posedge CLK48M) begin
        if (RESET) begin
            r_sndrq_d <= 1'b0;
            r_cs_d    <= 1'b0;
            r_overrun <= 1'b0;
            r_irq_cnt <= '0;
        end else begin
            r_sndrq_d <= SNDRQ;
            r_cs_d    <= SCPU_CS_LATCH;
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end
            r_irq_cnt <= (r_irq_cnt == IRQ_LAST) ? '0 : r_irq_cnt + IRQ_ONE;
        end
    end

    always_ff @(posedge CLK48M) begin
        if (RESET) begin
            r_state   <= IDLE;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_gap_cnt <= w_gap_cnt_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_gap_cnt_next = r_gap_cnt;
        case (r_state)
            IDLE: begin
                if (w_pending) begin
                    w_state_next = ASSERT;
                end
            end
            ASSERT: begin
                if (w_pop) begin
                    w_state_next   = GAP;
                    w_gap_cnt_next = '0;
                end
            end
            GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_next = IDLE;
                end else begin
                    w_gap_cnt_next = r_gap_cnt + GAP_ONE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign SCPU_LATCH_DO = w_do;
    assign SCPU_NMI      = (r_state == ASSERT);
    assign SCPU_IRQ      = (r_irq_cnt >= IRQ_ON);
    assign PENDING       = w_pending;
    assign OVERRUN       = r_overrun;

endmodule

// File: tb/tb_segasys1_sndlatch.sv
// Bench for segasys1_sndlatch: directed vector table, corner sequences and a random run,
// all checked every cycle against a queue-based model of the command path.
module tb_segasys1_sndlatch;

    localparam int P     = 20;
    localparam int W     = 3;
    localparam int GAPC  = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
`ifdef SNDLATCH_FIFO_EN
    localparam bit FIFO_MODE = 1'b1;
`else
    localparam bit FIFO_MODE = 1'b0;
`endif
    localparam int CAP = FIFO_MODE ? DEPTH : 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sndrq = 1'b0;
    logic [7:0] cpudo = 8'h00;
    logic       cs = 1'b0;
    logic [7:0] latch_do;
    logic       nmi, irq, pending, overrun;

    int n_tests = 0;
    int n_fail  = 0;

    segasys1_sndlatch #(
        .IRQ_PERIOD (P),
        .IRQ_WIDTH  (W),
        .NMI_GAP    (GAPC),
        .FIFO_AW    (AW)
    ) dut (
        .CLK48M        (clk),
        .RESET         (rst),
        .SNDRQ         (sndrq),
        .CPUDO         (cpudo),
        .SCPU_CS_LATCH (cs),
        .SCPU_LATCH_DO (latch_do),
        .SCPU_NMI      (nmi),
        .SCPU_IRQ      (irq),
        .PENDING       (pending),
        .OVERRUN       (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference model: commands live in a queue; the single latch is a queue of one
    // that overwrites, the FIFO drops when full.
    logic [7:0] exp_q[$];
    logic [7:0] m_last = 8'h00;
    bit         m_ovr = 1'b0;
    bit         m_nmi = 1'b0;
    bit         m_prev_rq = 1'b0;
    bit         m_prev_cs = 1'b0;
    int         m_since = 1000;
    int         m_k = 0;

    task automatic model_step();
        bit wr, pop, pend_before;
        if (rst) begin
            exp_q.delete();
            m_last    = 8'h00;
            m_ovr     = 1'b0;
            m_nmi     = 1'b0;
            m_prev_rq = 1'b0;
            m_prev_cs = 1'b0;
            m_since   = 1000;
            m_k       = 0;
            return;
        end
        pend_before = (exp_q.size() != 0);
        wr  = sndrq && !m_prev_rq;
        pop = !cs && m_prev_cs && pend_before;
        if (m_since < 1000) m_since++;
        if (m_nmi) begin
            if (pop) begin
                m_nmi   = 1'b0;
                m_since = 0;
            end
        end else if (pend_before && m_since >= GAPC + 1) begin
            m_nmi = 1'b1;
        end
        if (pop) m_last = exp_q.pop_front();
        if (wr) begin
            if (exp_q.size() < CAP) begin
                exp_q.push_back(cpudo);
            end else begin
                m_ovr = 1'b1;
                if (!FIFO_MODE) begin
                    exp_q.delete();
                    exp_q.push_back(cpudo);
                end
            end
        end
        m_prev_rq = sndrq;
        m_prev_cs = cs;
        m_k++;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        logic [7:0] exp_do;
        model_step();
        @(posedge clk);
        @(negedge clk);
        exp_do = (exp_q.size() != 0) ? exp_q[0] : m_last;
        check("model_do", latch_do, exp_do);
        check("model_pending", pending, 8'(exp_q.size() != 0));
        check("model_nmi", nmi, 8'(m_nmi));
        check("model_irq", irq, 8'((m_k % P) >= (P - W)));
        check("model_overrun", overrun, 8'(m_ovr));
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1; sndrq = 1'b0; cs = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic write_cmd(input logic [7:0] d);
        cpudo = d; sndrq = 1'b1;
        cycles(2);
        sndrq = 1'b0;
        cycles(2);
    endtask

    task automatic wait_nmi();
        int t = 0;
        while (nmi !== 1'b1 && t < 40) begin
            cycle();
            t++;
        end
        check("nmi_wait", nmi, 8'h01);
    endtask

    typedef struct {
        logic       rst;
        logic       rq;
        logic [7:0] d;
        logic       cs;
        logic       pend;
        logic       nmi;
        logic [7:0] dout;
        logic       ovr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic q, logic [7:0] d, logic c,
                                logic p, logic n, logic [7:0] o, logic v);
        vec_t t;
        t.rst = r; t.rq = q; t.d = d; t.cs = c;
        t.pend = p; t.nmi = n; t.dout = o; t.ovr = v;
        return t;
    endfunction

    initial begin
        int low_cnt;

        // Reset, idle, one 8-cycle write of $A5, then a 6-cycle read.
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 8'h00, 0));
        for (int i = 0; i < 10; i++) tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 0));
        tbl.push_back(mk(0, 1, 8'hA5, 0, 1, 0, 8'hA5, 0));
        for (int i = 0; i < 7; i++) tbl.push_back(mk(0, 1, 8'hA5, 0, 1, 1, 8'hA5, 0));
        tbl.push_back(mk(0, 0, 8'hA5, 0, 1, 1, 8'hA5, 0));
        for (int i = 0; i < 6; i++) tbl.push_back(mk(0, 0, 8'hA5, 1, 1, 1, 8'hA5, 0));
        for (int i = 0; i < 6; i++) tbl.push_back(mk(0, 0, 8'hA5, 0, 0, 0, 8'hA5, 0));

        foreach (tbl[i]) begin
            rst = tbl[i].rst; sndrq = tbl[i].rq; cpudo = tbl[i].d; cs = tbl[i].cs;
            cycle();
            check($sformatf("tbl%0d_pending", i), pending, 8'(tbl[i].pend));
            check($sformatf("tbl%0d_nmi", i), nmi, 8'(tbl[i].nmi));
            check($sformatf("tbl%0d_do", i), latch_do, tbl[i].dout);
            check($sformatf("tbl%0d_overrun", i), overrun, 8'(tbl[i].ovr));
        end

        // SNDRQ held high across a read, then re-raised after 3 low cycles: one new write.
        do_reset();
        cpudo = 8'h3C; sndrq = 1'b1;
        cycles(3);
        cs = 1'b1;
        cycles(3);
        cs = 1'b0;
        cycle();
        check("held_pop_pending", pending, 8'h00);
        cycles(3);
        check("held_no_rewrite", pending, 8'h00);
        sndrq = 1'b0;
        cycles(3);
        cpudo = 8'h4D; sndrq = 1'b1;
        cycle();
        check("rewrite_pending", pending, 8'h01);
        check("rewrite_do", latch_do, 8'h4D);
        cycles(4);
        sndrq = 1'b0;
        cycles(2);
        check("rewrite_single", overrun, 8'h00);
        cs = 1'b1;
        cycles(2);
        cs = 1'b0;
        cycle();
        check("rewrite_drained", pending, 8'h00);
        cycles(6);

`ifdef SNDLATCH_FIFO_EN
        // Fill the FIFO, overflow it, then drain with NMI gap measurement.
        do_reset();
        for (int v = 1; v <= 4; v++) write_cmd(8'(v));
        write_cmd(8'h05);
        check("fifo_overrun", overrun, 8'h01);
        for (int i = 0; i < 4; i++) begin
            wait_nmi();
            check($sformatf("fifo_order%0d", i), latch_do, 8'(i + 1));
            cs = 1'b1;
            cycles(2);
            cs = 1'b0;
            cycle();
            low_cnt = 0;
            while (nmi === 1'b0 && low_cnt < 30) begin
                low_cnt++;
                cycle();
            end
            if (i < 3) check($sformatf("fifo_nmi_low%0d", i), 8'(low_cnt), 8'(GAPC + 1));
        end
        check("fifo_drained", pending, 8'h00);
        check("fifo_last_do", latch_do, 8'h04);
`else
        // Two writes with no read: the second overwrites and flags an overrun.
        do_reset();
        write_cmd(8'h11);
        write_cmd(8'h22);
        check("latch_do", latch_do, 8'h22);
        check("latch_overrun", overrun, 8'h01);
        check("latch_pending", pending, 8'h01);
`endif

        // Write and pop in the same cycle on a single pending entry.
        do_reset();
        write_cmd(8'h66);
        cs = 1'b1;
        cycles(2);
        cs = 1'b0; cpudo = 8'h77; sndrq = 1'b1;
        cycle();
        check("coinc_pending", pending, 8'h01);
        check("coinc_do", latch_do, 8'h77);
        check("coinc_overrun", overrun, 8'h00);
        sndrq = 1'b0;
        cycles(8);
        check("coinc_nmi_again", nmi, 8'h01);

        // IRQ: high in cycles 17..19 and 37..39 after reset; reset at 38 kills it at 39.
        do_reset();
        check("irq_c0", irq, 8'h00);
        for (int k = 1; k <= 38; k++) begin
            cycle();
            check($sformatf("irq_c%0d", k), irq, 8'((k % P) >= (P - W)));
        end
        rst = 1'b1;
        cycle();
        check("irq_reset", irq, 8'h00);
        rst = 1'b0;

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (!sndrq && $urandom_range(0, 5) == 0) begin
                cpudo = 8'($urandom_range(0, 255));
                sndrq = 1'b1;
            end else if (sndrq && $urandom_range(0, 2) == 0) begin
                sndrq = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) cs = ~cs;
            cycle();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
